// File: rtl/sram_pkg.sv
// sram_pkg: shared types, widths and boot image for the SLC-3 SRAM responder.
package sram_pkg;
    localparam int DATA_W  = 16;
    localparam int IMG_LEN = 8;
    typedef enum logic {INIT, SERVE} state_e;
    typedef enum logic [1:0] {ACC_IDLE, ACC_READ, ACC_WRITE} acc_e;
    // Boot program copied into words 0..IMG_LEN-1; every other word loads as zero.
    localparam logic [DATA_W-1:0] INIT_IMAGE [IMG_LEN] = '{
        16'h5020, 16'h1221, 16'h1022, 16'h3005,
        16'h2004, 16'h0FFB, 16'hF025, 16'h00A5
    };
endpackage

// File: rtl/sram_init_rom.sv
// sram_init_rom: combinational boot-image lookup; unlisted addresses read as zero.
module sram_init_rom
    import sram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-1:0]     addr_i,
    output logic [DATA_W-1:0] word_o
);
    always_comb begin
        case (addr_i)
            AW'(0):  word_o = INIT_IMAGE[0];
            AW'(1):  word_o = INIT_IMAGE[1];
            AW'(2):  word_o = INIT_IMAGE[2];
            AW'(3):  word_o = INIT_IMAGE[3];
            AW'(4):  word_o = INIT_IMAGE[4];
            AW'(5):  word_o = INIT_IMAGE[5];
            AW'(6):  word_o = INIT_IMAGE[6];
            AW'(7):  word_o = INIT_IMAGE[7];
            default: word_o = '0;
        endcase
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: SLC-3 SRAM bus memory model; boots from sram_init_rom, then serves byte-laned accesses.
// Define SRAM_WRITE_PROTECT_EN to block writes at or below PROTECT_TOP and flag them on Prot_Viol.
module sram_responder
    import sram_pkg::*;
#(
    parameter int            AW          = 10,
    parameter logic [AW-1:0] PROTECT_TOP = AW'('h05F)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [19:0]       ADDR,
    inout  wire  [DATA_W-1:0] Data,
    output logic              Init_Done,
    output logic              Prot_Viol
);
`ifdef SRAM_WRITE_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif
    state_e            state_q;
    logic [AW-1:0]     cnt_q;
    logic [DATA_W-1:0] rd_q, rd_d, rom_word;
    logic              done_q, viol_q;
    logic [DATA_W-1:0] mem [2**AW];
    logic [AW-1:0]     a;
    logic              in_rng, blocked;
    acc_e              acc;
    sram_init_rom #(.AW(AW)) u_rom (.addr_i(cnt_q), .word_o(rom_word));
    assign a         = ADDR[AW-1:0];
    assign in_rng    = ADDR[19:AW] == '0;
    assign acc       = CE ? ACC_IDLE : !WE ? ACC_WRITE : !OE ? ACC_READ : ACC_IDLE;
    assign blocked   = PROT_EN && state_q == SERVE && acc == ACC_WRITE && in_rng && a <= PROTECT_TOP;
    assign rd_d      = acc == ACC_READ ? (in_rng ? mem[a] : '0) : rd_q;
    // Release the bus immediately on reset, not one edge later.
    assign Data      = (!Reset && state_q == SERVE && acc == ACC_READ) ? rd_q : 'z;
    assign Init_Done = done_q;
    assign Prot_Viol = viol_q;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            viol_q  <= 1'b0;
            rd_q    <= '0;
        end else if (state_q == INIT) begin
            mem[cnt_q] <= rom_word;
            cnt_q      <= cnt_q + 1'b1;
            if (&cnt_q) begin
                state_q <= SERVE;
                done_q  <= 1'b1;
            end
        end else begin
            rd_q   <= rd_d;
            viol_q <= blocked;
            if (acc == ACC_WRITE && in_rng && !blocked) begin
                if (!LB) mem[a][7:0]  <= Data[7:0];
                if (!UB) mem[a][15:8] <= Data[15:8];
            end
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized and directed checks of sram_responder against an array reference model.
module tb_sram_responder;
    import sram_pkg::*;
    logic        Clk = 1'b0, Reset = 1'b1;
    logic        CE = 1'b1, UB = 1'b1, LB = 1'b1, OE = 1'b1, WE = 1'b1;
    logic [19:0] ADDR = '0;
    logic [15:0] tb_d = '0;
    logic        tb_oe = 1'b0;
    tri1  [15:0] Data;
    logic        Init_Done, Prot_Viol;
    int          total = 0, bad = 0;
    logic [15:0] model [1024];
`ifdef SRAM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    assign Data = tb_oe ? tb_d : 'z;
    sram_responder dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data(Data), .Init_Done(Init_Done), .Prot_Viol(Prot_Viol)
    );
    always #5 Clk = ~Clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // One bus cycle: drive after a falling edge, let the responder sample, check at the next falling edge.
    task automatic bus(input logic ce, we, oe, ub, lb, input logic [19:0] ad, input logic [15:0] wd);
        logic rd, wr, inr, blk;
        logic [15:0] erd;
        CE = ce; WE = we; OE = oe; UB = ub; LB = lb; ADDR = ad; tb_d = wd;
        tb_oe = !we && (!ub || !lb);
        rd  = !ce && we && !oe;
        wr  = !ce && !we;
        inr = ad[19:10] == 10'd0;
        blk = PROT && wr && inr && ad[9:0] <= 10'h05F;
        erd = inr ? model[ad[9:0]] : 16'h0000;
        @(posedge Clk);
        if (wr && inr && !blk) begin
            if (!lb) model[ad[9:0]][7:0]  = wd[7:0];
            if (!ub) model[ad[9:0]][15:8] = wd[15:8];
        end
        @(negedge Clk);
        chk($sformatf("viol@%h", ad), {31'd0, Prot_Viol}, {31'd0, blk});
        if (rd) chk($sformatf("rd@%h", ad), {16'd0, Data}, {16'd0, erd});
        else if (!tb_oe) chk($sformatf("float@%h", ad), {16'd0, Data}, 32'hFFFF);
    endtask
    initial begin
        int n, zb;
        CE = 1'b0; OE = 1'b0; WE = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_done", {31'd0, Init_Done}, 0);
        chk("rst_viol", {31'd0, Prot_Viol}, 0);
        chk("rst_z", {16'd0, Data}, 32'hFFFF);
        Reset = 1'b0;
        repeat (500) @(negedge Clk);
        chk("mid_load_done", {31'd0, Init_Done}, 0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        n = 0; zb = 0;
        while (n < 3000) begin
            @(negedge Clk);
            n++;
            if (Init_Done) break;
            if (Data !== 16'hFFFF) zb++;
        end
        chk("load_cycles", n, 1024);
        chk("init_z", zb, 0);
        for (int i = 0; i < 1024; i++) model[i] = i < IMG_LEN ? INIT_IMAGE[i] : 16'h0000;
        bus(0, 1, 0, 1, 1, 20'h00000, 0);
        bus(0, 1, 0, 1, 1, 20'h003FF, 0);
        bus(0, 0, 1, 0, 0, 20'h00200, 16'hA0A0);
        bus(0, 1, 0, 1, 1, 20'h00200, 0);
        bus(0, 0, 1, 1, 0, 20'h00200, 16'h1234);
        bus(0, 1, 0, 1, 1, 20'h00200, 0);
        bus(0, 0, 1, 0, 1, 20'h00200, 16'h5600);
        bus(0, 1, 0, 1, 1, 20'h00200, 0);
        bus(0, 0, 0, 0, 0, 20'h00201, 16'hFFFF);
        bus(0, 0, 0, 1, 1, 20'h00201, 0);
        bus(0, 1, 0, 1, 1, 20'h00201, 0);
        bus(0, 1, 0, 1, 1, 20'h00400, 0);
        bus(0, 0, 1, 0, 0, 20'h00400, 16'h1111);
        bus(0, 1, 0, 1, 1, 20'h00000, 0);
        bus(0, 1, 0, 1, 1, 20'h80005, 0);
        for (int i = 0; i < IMG_LEN; i++) bus(0, 1, 0, 1, 1, 20'(i), 0);
        bus(0, 0, 1, 0, 0, 20'h00050, 16'hBEEF);
        bus(0, 1, 0, 1, 1, 20'h00050, 0);
        bus(0, 0, 1, 0, 0, 20'h00060, 16'h7777);
        bus(0, 1, 0, 1, 1, 20'h00060, 0);
        bus(0, 0, 1, 0, 0, 20'h0005F, 16'hC0DE);
        bus(0, 0, 1, 0, 0, 20'h00000, 16'hDEAD);
        bus(1, 1, 1, 1, 1, 20'h00000, 0);
        bus(0, 1, 0, 1, 1, 20'h0005F, 0);
        bus(0, 1, 0, 1, 1, 20'h00000, 0);
        for (int i = 0; i < 400; i++) begin
            logic [19:0] ad;
            ad = $urandom_range(0, 7) == 0 ? 20'($urandom_range(1024, 20'hFFFFF))
               : $urandom_range(0, 1) ? 20'($urandom_range(0, 127)) : 20'($urandom_range(0, 1023));
            bus($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ad, 16'($urandom));
        end
        bus(0, 1, 0, 1, 1, 20'h00200, 0);
        Reset = 1'b1;
        #1;
        chk("rst_release", {16'd0, Data}, 32'hFFFF);
        @(negedge Clk);
        chk("rst_done_clr", {31'd0, Init_Done}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
